melody_player: RTL and testbench
================================

Name: melody_player

Overview:
- Sequencer that plays a stored reference melody through the piano tone datapath (piano_octave) for pitch-training prompts.
- Holds up to DEPTH note entries (note id, octave, duration in ms), written by the host/control logic.
- On start, drives piano_keys / octave_num / play_en entry by entry, with a fixed silent gap between notes, then pulses done.
- Sits between the system control FSM and piano_octave; muxing against live keyboard keys is handled outside this block.

Parameters:
- DEPTH, 16, number of melody entries (power of 2, max 16).
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clock).
- GAP_MS, 20, silent ms between consecutive notes; 0 means no gap.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous reset, active-high
- wr_en  in  1  write entry wr_addr this cycle
- wr_addr  in  4  entry index
- wr_note  in  4  note id: 1..12 = F..E (same encoding as piano_played_octid); 0 or 13..15 = rest
- wr_oct  in  3  octave for the entry
- wr_dur  in  12  note duration in ms; 0 is treated as 1
- seq_len  in  5  number of entries to play; sampled on start
- start  in  1  single-cycle pulse to begin playback
- stop  in  1  single-cycle pulse to abort playback
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence completes normally
- cur_idx  out  4  index of the entry being played
- piano_keys  out  12  one-hot key vector to piano_octave; bit n-1 = note n
- octave_num  out  3  octave to piano_octave
- play_en  out  1  tone enable to piano_octave

Behaviour:
- Memory: DEPTH x 19-bit register file, written synchronously whenever wr_en=1, in any state. Not cleared by reset.
- Writes during playback are permitted. The entry currently playing is latched at LOAD, so a write to it affects only later plays.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- Reset: state=IDLE; busy, done, cur_idx, piano_keys, octave_num, play_en all 0; counters 0.
- IDLE:
  - start with seq_len==0: done pulses the next cycle; state stays IDLE.
  - start with seq_len>0: len_r = min(seq_len, DEPTH), cur_idx=0, go to LOAD.
- LOAD (1 cycle):
  - Latch the entry at cur_idx: note, octave, ms_cnt = max(dur,1).
  - Clear the tick counter; go to PLAY.
- PLAY:
  - play_en=1 and octave_num=latched octave.
  - piano_keys = one-hot of the note, or all zeros for a rest; play_en stays 1 for rests.
  - Tick counter runs 0..TICK_DIV-1. On wrap, ms_cnt decrements.
  - When ms_cnt==1 at wrap:
    - GAP_MS>0: go to GAP with ms_cnt=GAP_MS.
    - GAP_MS==0: advance.
  - Note length is exactly dur*TICK_DIV cycles.
- GAP: piano_keys=0, play_en=0; octave_num holds. Same tick/ms countdown as PLAY, then advance.
- Advance:
  - cur_idx+1 == len_r: go to DONE.
  - Otherwise cur_idx increments and the FSM goes to LOAD, so each note is preceded by one LOAD cycle with keys=0 and play_en=0.
- DONE (1 cycle): done=1; keys=0, play_en=0; next state IDLE. cur_idx holds its last value until the next start.
- Latency: start registered at cycle 0 → LOAD at cycle 1 → piano_keys valid at cycle 2. busy rises at cycle 1 and falls the cycle after DONE.
- stop:
  - In any non-IDLE state, the next state is IDLE; keys, play_en and busy go 0 the next cycle; no done pulse.
  - stop in IDLE is a no-op.
  - If start and stop arrive in the same cycle, stop wins.
- start while busy is ignored; it never restarts the sequence.
- reset mid-playback has the same output effect as stop and also clears cur_idx.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All cases use TICK_DIV=4, GAP_MS=2.
- Basic: write entries 0:(note 1, oct 3, dur 3) and 1:(note 12, oct 4, dur 2); seq_len=2; pulse start.
  → piano_keys=12'h001, oct 3 for 12 cycles starting at cycle 2; 0 for 8 gap cycles; 1 LOAD cycle; then 12'h800, oct 4 for 8 cycles; 8 gap cycles; done pulses once; busy falls the next cycle.
- Rest and zero duration: entry 0 = (note 0, dur 0), seq_len=1.
  → play_en=1 with keys=0 for 4 cycles, 8 gap cycles, done.
- Edge lengths: seq_len=0 → done the next cycle, busy never rises. seq_len=20 with DEPTH=16 → plays exactly 16 entries, cur_idx runs 0..15.
- stop mid-note (and stop+start in the same cycle) → next cycle IDLE, keys=0, play_en=0, no done pulse. A second start then replays from index 0.
- start while busy → ignored; total play time is unchanged.
- Write during playback: overwrite entry 0 while entry 0 plays → the current note is unchanged; the next start plays the new value. reset mid-GAP → all outputs 0 the next cycle.

Source files
------------

// File: rtl/melody_player.sv
// Reference-melody sequencer: steps through a small note table and drives the
// piano tone datapath (keys / octave / enable) with a silent gap between notes.
module melody_player #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned GAP_MS   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [3:0]  wr_note,
  input  logic [2:0]  wr_oct,
  input  logic [11:0] wr_dur,
  input  logic [4:0]  seq_len,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        done,
  output logic [3:0]  cur_idx,
  output logic [11:0] piano_keys,
  output logic [2:0]  octave_num,
  output logic        play_en
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned EW = 19;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [4:0]    len_r, len_n;
  logic [3:0]    idx_n;
  logic [11:0]   ms_cnt, ms_n;
  logic [TW-1:0] tick, tick_n;
  logic [11:0]   keys_n;
  logic [2:0]    oct_n;
  logic          play_n, busy_n, done_n;
  logic          adv;

  // Entry layout: {note[3:0], octave[2:0], dur_ms[11:0]}
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd;
  logic [3:0]    rd_note;
  logic [2:0]    rd_oct;
  logic [11:0]   rd_dur;
  logic          tick_wrap;

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < 5'(DEPTH)))
      mem[AW'(wr_addr)] <= {wr_note, wr_oct, wr_dur};
  end

  assign rd        = mem[AW'(cur_idx)];
  assign rd_note   = rd[18:15];
  assign rd_oct    = rd[14:12];
  assign rd_dur    = rd[11:0];
  assign tick_wrap = (tick == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      len_r      <= '0;
      cur_idx    <= '0;
      ms_cnt     <= '0;
      tick       <= '0;
      piano_keys <= '0;
      octave_num <= '0;
      play_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      len_r      <= len_n;
      cur_idx    <= idx_n;
      ms_cnt     <= ms_n;
      tick       <= tick_n;
      piano_keys <= keys_n;
      octave_num <= oct_n;
      play_en    <= play_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_n = state;
    len_n   = len_r;
    idx_n   = cur_idx;
    ms_n    = ms_cnt;
    tick_n  = tick;
    keys_n  = piano_keys;
    oct_n   = octave_num;
    play_n  = play_en;
    busy_n  = busy;
    done_n  = 1'b0;
    adv     = 1'b0;

    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        play_n = 1'b0;
        keys_n = '0;
        if (start && !stop) begin
          if (seq_len == 5'd0) begin
            done_n = 1'b1;
          end else begin
            len_n   = (seq_len > 5'(DEPTH)) ? 5'(DEPTH) : seq_len;
            idx_n   = '0;
            busy_n  = 1'b1;
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        ms_n    = (rd_dur == 12'd0) ? 12'd1 : rd_dur;
        tick_n  = '0;
        oct_n   = rd_oct;
        keys_n  = (rd_note >= 4'd1 && rd_note <= 4'd12) ? (12'd1 << (rd_note - 4'd1)) : 12'd0;
        play_n  = 1'b1;
        state_n = S_PLAY;
      end
      S_PLAY, S_GAP: begin
        if (tick_wrap) begin
          tick_n = '0;
          if (ms_cnt == 12'd1) begin
            if (state == S_PLAY && GAP_MS != 0) begin
              ms_n    = 12'(GAP_MS);
              keys_n  = '0;
              play_n  = 1'b0;
              state_n = S_GAP;
            end else begin
              adv = 1'b1;
            end
          end else begin
            ms_n = ms_cnt - 12'd1;
          end
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (adv) begin
      keys_n = '0;
      play_n = 1'b0;
      if (5'(cur_idx) + 5'd1 == len_r) begin
        done_n  = 1'b1;
        state_n = S_DONE;
      end else begin
        idx_n   = cur_idx + 4'd1;
        state_n = S_LOAD;
      end
    end

    // Abort wins over everything else once a sequence is underway
    if (stop && state != S_IDLE) begin
      state_n = S_IDLE;
      keys_n  = '0;
      play_n  = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Randomized bench for melody_player: a per-cycle expected trace is built from
// the note table contents and compared against the outputs every cycle.
module tb_melody_player;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TICK  = 4;
  localparam int unsigned GAP   = 2;

  logic        clk = 1'b0;
  logic        reset, wr_en, start, stop;
  logic [3:0]  wr_addr, wr_note;
  logic [2:0]  wr_oct;
  logic [11:0] wr_dur;
  logic [4:0]  seq_len;
  logic        busy, done, play_en;
  logic [3:0]  cur_idx;
  logic [11:0] piano_keys;
  logic [2:0]  octave_num;

  int n_cmp = 0;
  int n_bad = 0;

  int sh_note [DEPTH];
  int sh_oct  [DEPTH];
  int sh_dur  [DEPTH];

  typedef struct packed {
    logic [11:0] keys;
    logic [2:0]  oct;
    logic        play;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } exp_t;

  exp_t exp_q[$];

  melody_player #(.DEPTH(DEPTH), .TICK_DIV(TICK), .GAP_MS(GAP)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
    .wr_oct(wr_oct), .wr_dur(wr_dur), .seq_len(seq_len), .start(start), .stop(stop),
    .busy(busy), .done(done), .cur_idx(cur_idx), .piano_keys(piano_keys),
    .octave_num(octave_num), .play_en(play_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int n, input int o, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_note = 4'(n); wr_oct = 3'(o); wr_dur = 12'(d);
    sh_note[a] = n; sh_oct[a] = o; sh_dur[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int idx);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_play"}, 32'(play_en), 32'(0));
    check({tag, "_keys"}, 32'(piano_keys), 32'(0));
    check({tag, "_idx"}, 32'(cur_idx), 32'(idx));
  endtask

  // Expected outputs from the cycle after start until back in idle
  task automatic build_exp(input int slen);
    int n;
    int d;
    logic [11:0] k;
    n = (slen > int'(DEPTH)) ? int'(DEPTH) : slen;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      d = (sh_dur[i] == 0) ? 1 : sh_dur[i];
      k = (sh_note[i] >= 1 && sh_note[i] <= 12) ? 12'(1 << (sh_note[i] - 1)) : 12'd0;
      exp_q.push_back('{keys: 12'd0, oct: 3'd0, play: 1'b0, busy: 1'b1, done: 1'b0, idx: 4'(i)});
      for (int t = 0; t < d * int'(TICK); t++)
        exp_q.push_back('{keys: k, oct: 3'(sh_oct[i]), play: 1'b1, busy: 1'b1, done: 1'b0, idx: 4'(i)});
      for (int t = 0; t < int'(GAP * TICK); t++)
        exp_q.push_back('{keys: 12'd0, oct: 3'(sh_oct[i]), play: 1'b0, busy: 1'b1, done: 1'b0, idx: 4'(i)});
    end
    exp_q.push_back('{keys: 12'd0, oct: 3'd0, play: 1'b0, busy: 1'b1, done: 1'b1, idx: 4'(n - 1)});
    exp_q.push_back('{keys: 12'd0, oct: 3'd0, play: 1'b0, busy: 1'b0, done: 1'b0, idx: 4'(n - 1)});
  endtask

  task automatic run_seq(input int slen, input int stop_at, input bit stop_start,
                         input int rst_at, input int busy_start_at, input int wr_at);
    exp_t e;
    build_exp(slen);
    seq_len = 5'(slen);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      e = exp_q[c];
      check("busy", 32'(busy), 32'(e.busy));
      check("done", 32'(done), 32'(e.done));
      check("play_en", 32'(play_en), 32'(e.play));
      check("keys", 32'(piano_keys), 32'(e.keys));
      check("cur_idx", 32'(cur_idx), 32'(e.idx));
      if (e.play) check("octave", 32'(octave_num), 32'(e.oct));
      if (c == stop_at) begin
        stop = 1'b1; start = stop_start;
        step();
        stop = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check_idle("after_stop", int'(e.idx));
          step();
        end
        return;
      end
      if (c == rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("after_reset", 0);
        check("after_reset_oct", 32'(octave_num), 32'(0));
        step();
        check_idle("after_reset2", 0);
        return;
      end
      if (c == busy_start_at) begin
        start = 1'b1;
        seq_len = 5'd1;
      end
      if (c == wr_at) begin
        wr_en = 1'b1; wr_addr = 4'd0;
        sh_note[0] = int'($urandom_range(1, 12));
        sh_oct[0]  = int'($urandom_range(0, 7));
        sh_dur[0]  = int'($urandom_range(1, 3));
        wr_note = 4'(sh_note[0]); wr_oct = 3'(sh_oct[0]); wr_dur = 12'(sh_dur[0]);
      end
      step();
      start = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < int'(DEPTH); a++)
      write_entry(a, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)));
  endtask

  initial begin
    int gap_at;
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    wr_addr = '0; wr_note = '0; wr_oct = '0; wr_dur = '0; seq_len = '0;
    step(); step();
    reset = 1'b0;
    check_idle("reset", 0);
    check("reset_oct", 32'(octave_num), 32'(0));

    fill_random();

    // Two-note basic melody
    write_entry(0, 1, 3, 3);
    write_entry(1, 12, 4, 2);
    run_seq(2, -1, 1'b0, -1, -1, -1);

    // Rest with zero duration
    write_entry(0, 0, 5, 0);
    run_seq(1, -1, 1'b0, -1, -1, -1);

    // Empty sequence: done pulse only
    seq_len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("len0_done", 32'(done), 32'(1));
    check("len0_busy", 32'(busy), 32'(0));
    step();
    check("len0_done2", 32'(done), 32'(0));
    check("len0_busy2", 32'(busy), 32'(0));

    // Over-long sequence is clipped to the table depth
    run_seq(20, -1, 1'b0, -1, -1, -1);

    // Stop mid-note, stop together with start, then replay from index 0
    write_entry(0, 5, 2, 3);
    run_seq(3, 3, 1'b0, -1, -1, -1);
    run_seq(3, 6, 1'b1, -1, -1, -1);
    run_seq(2, -1, 1'b0, -1, -1, -1);

    // Start while busy is ignored
    run_seq(2, -1, 1'b0, -1, 5, -1);

    // Overwrite entry 0 while it plays; the next run uses the new value
    run_seq(2, -1, 1'b0, -1, -1, 2);
    run_seq(1, -1, 1'b0, -1, -1, -1);

    // Reset in the first gap
    gap_at = 1 + ((sh_dur[0] == 0) ? 1 : sh_dur[0]) * int'(TICK) + 3;
    run_seq(2, -1, 1'b0, gap_at, -1, -1);

    // Random tables and lengths
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_seq(int'($urandom_range(1, 5)), -1, 1'b0, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
